// File: rtl/mmap_pkg.sv
// Shared types and address map for the mmap bus arbiter.
package mmap_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  localparam logic [15:0] MMAP_ADDR_LO  = 16'hC00B;
  localparam logic [15:0] MMAP_ADDR_HI  = 16'hC016;

  localparam logic [15:0] ADDR_BR_STATS = 16'hC00B;
  localparam logic [15:0] ADDR_C00F     = 16'hC00F;
  localparam logic [15:0] ADDR_C010     = 16'hC010;
  localparam logic [15:0] ADDR_C011     = 16'hC011;
  localparam logic [15:0] ADDR_C012     = 16'hC012;
  localparam logic [15:0] ADDR_C013     = 16'hC013;
  localparam logic [15:0] ADDR_C014     = 16'hC014;
  localparam logic [15:0] ADDR_C015     = 16'hC015;
  localparam logic [15:0] ADDR_LFSR     = 16'hC016;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

endpackage

// File: rtl/mmap_bus_arbiter_if.sv
// Requester-side handshakes plus register-bank bus of the mmap arbiter.
interface mmap_bus_arbiter_if;
  logic        req0, req1;
  logic        we0, we1;
  logic [15:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1;
  logic        done0, done1;
  logic [15:0] rdata;
  logic        err;
  logic        mm_re;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_oe;
  logic [15:0] bus_rdata;
  logic        br_stats_wr;
  logic        lfsr_load;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bus_rdata,
    output gnt0, gnt1, done0, done1, rdata, err, mm_re, bus_addr, bus_wdata, bus_oe,
           br_stats_wr, lfsr_load
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bus_rdata,
    input  gnt0, gnt1, done0, done1, rdata, err, mm_re, bus_addr, bus_wdata, bus_oe,
           br_stats_wr, lfsr_load
  );
endinterface

// File: rtl/mmap_bus_arbiter_rr_arb2.sv
// Two-way round-robin selector: on a tie, the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/mmap_bus_arbiter.sv
// Arbitrates two requesters onto a memory-mapped register bank.
// Out-of-range requests skip the bus phase and complete with err.
module mmap_bus_arbiter
  import mmap_pkg::*;
#(
  parameter logic [15:0] ADDR_LO = MMAP_ADDR_LO,
  parameter logic [15:0] ADDR_HI = MMAP_ADDR_HI
) (
  input logic               clk,
  input logic               rst,
  mmap_bus_arbiter_if.slave bus
);
  state_e      r_state, w_state_next;
  txn_t        r_txn, w_sel_txn;
  logic        r_owner, r_last, r_err;
  logic [15:0] r_rdata;
  logic [1:0]  w_req, w_rr_gnt, w_gnt;
  logic        w_in_range, w_access, w_resp, w_wr;

  assign w_req = {bus.req1, bus.req0};

  rr_arb2 u_rr_arb2 (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_rr_gnt)
  );

  // Grant is combinational in IDLE so the accepting edge also latches the request.
  assign w_gnt = (r_state == StIdle && !rst) ? w_rr_gnt : 2'b00;

  always_comb begin
    w_sel_txn = '0;
    if (w_gnt[1]) begin
      w_sel_txn = '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};
    end else begin
      w_sel_txn = '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
    end
  end

  assign w_in_range = (w_sel_txn.addr >= ADDR_LO) && (w_sel_txn.addr <= ADDR_HI);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (|w_gnt) w_state_next = w_in_range ? StAccess : StResp;
      StAccess: w_state_next = StResp;
      StResp:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_txn   <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_err   <= 1'b0;
      r_rdata <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      if (|w_gnt) begin
        r_txn   <= w_sel_txn;
        r_owner <= w_gnt[1];
        r_last  <= w_gnt[1];
        r_err   <= !w_in_range;
        r_rdata <= 16'h0000;
      end
      if (r_state == StAccess) begin
        r_rdata <= r_txn.we ? 16'h0000 : bus.bus_rdata;
      end
    end
  end

  assign w_access = (r_state == StAccess);
  assign w_resp   = (r_state == StResp);
  assign w_wr     = w_access && r_txn.we;

  always_comb begin
    bus.gnt0        = w_gnt[0];
    bus.gnt1        = w_gnt[1];
    bus.done0       = w_resp && !r_owner;
    bus.done1       = w_resp && r_owner;
    bus.err         = w_resp && r_err;
    bus.rdata       = r_rdata;
    bus.mm_re       = w_access && !r_txn.we;
    bus.bus_oe      = w_wr;
    bus.bus_addr    = w_access ? r_txn.addr : 16'h0000;
    bus.bus_wdata   = w_wr ? r_txn.wdata : 16'h0000;
    bus.br_stats_wr = w_wr && (r_txn.addr == ADDR_BR_STATS);
    bus.lfsr_load   = w_wr && (r_txn.addr == ADDR_LFSR);
  end

endmodule

// File: doc/mmap_bus_arbiter.md
MMAP_BUS_ARBITER -- requirements
Module: mmap_bus_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter: ADDR_LO, 16'hC00B, lowest decoded mmap address.
REQ-003 Parameter: ADDR_HI, 16'hC016, highest decoded mmap address.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 req0, req1  in  1  access request from requester 0 (CPU) and requester 1 (debug bridge); held high until done.
REQ-007 we0, we1  in  1  1 = write, 0 = read; sampled with the request.
REQ-008 addr0, addr1  in  16  target mmap address; sampled with the request.
REQ-009 wdata0, wdata1  in  16  write data; sampled with the request.
REQ-010 gnt0, gnt1  out  1  one-cycle pulse marking acceptance of the requester's transaction.
REQ-011 done0, done1  out  1  one-cycle pulse marking completion; rdata and err are valid in that cycle.
REQ-012 rdata  out  16  read data returned to the requester being completed.
REQ-013 err  out  1  asserted together with done when the address is outside ADDR_LO..ADDR_HI.
REQ-014 mm_re  out  1  read strobe to the register bank.
REQ-015 bus_addr  out  16  address presented to the register bank.
REQ-016 bus_wdata, bus_oe  out  16, 1  write data and its drive enable onto the shared databus.
REQ-017 bus_rdata  in  16  databus value sampled during a read.
REQ-018 br_stats_wr, lfsr_load  out  1  write strobes for 16'hC00B and 16'hC016 respectively.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS and RESP.
- IDLE -> ACCESS when any request is present and in range.
- IDLE -> RESP directly for an out-of-range request.
- ACCESS -> RESP always.
- RESP -> IDLE always.
REQ-020 In IDLE, with only one requester active, that requester SHALL be granted.
REQ-021 In IDLE, with both requesters active, the requester not granted most recently SHALL be granted (round-robin); the last-grant pointer updates on each grant.
REQ-022 On grant, gnt SHALL pulse for one cycle, and the requester's we, addr and wdata SHALL be latched into internal registers.
REQ-023 In ACCESS, bus_addr SHALL equal the latched address.
- Read: mm_re = 1.
- Write: bus_oe = 1, bus_wdata = latched wdata, and the matching strobe pulses for exactly one cycle.
REQ-024 bus_rdata SHALL be captured into rdata at the end of ACCESS for reads.
REQ-025 Writes SHALL return rdata = 16'h0000.
REQ-026 In RESP, the granted requester's done SHALL pulse for one cycle.
REQ-027 A write to an in-range address other than C00B/C016 SHALL complete normally with no strobe.
REQ-028 An out-of-range request SHALL NOT drive mm_re, bus_oe or any strobe; it completes in RESP with err = 1 and rdata = 16'h0000.
REQ-029 Latency SHALL be grant to done = 2 cycles in range and 1 cycle out of range; throughput is at most one transaction per 3 cycles.
REQ-030 A request arriving while busy SHALL wait; requests SHALL NOT be dropped or reordered within one requester.
REQ-031 A requester deasserting req before grant SHALL be treated as if it never requested.
REQ-032 Deasserting req after grant SHALL NOT abort the transaction.
REQ-033 mm_re and bus_oe SHALL never be high in the same cycle.
REQ-034 gnt0/gnt1 SHALL be mutually exclusive, and done0/done1 SHALL be mutually exclusive.

Reset
REQ-035 Reset SHALL force: state = IDLE, all outputs 0, bus_addr = 16'h0000, rdata = 16'h0000, and the last-grant pointer pointing to requester 1 (so requester 0 wins the first tie).
REQ-036 Reset asserted mid-transaction SHALL immediately drop all strobes and drives, and no done SHALL be issued for the aborted transaction.

Structure
REQ-037 A shared package mmap_pkg SHALL hold the FSM state enum, the address constants (C00B, C00F, C010..C016, ADDR_LO/ADDR_HI) and a transaction struct {we, addr, wdata}.
REQ-038 Round-robin selection SHALL be a sub-module rr_arb2 (req[1:0], last pointer -> one-hot grant).
REQ-039 The FSM and datapath SHALL live in mmap_bus_arbiter.

Verification
REQ-040 Single read: req0 reads C013 with bus_rdata = 16'h1234 -> gnt0 at T, mm_re at T+1, done0 at T+2 with rdata = 16'h1234 and err = 0.
REQ-041 Tie: req0 and req1 both assert from reset -> gnt0 first, gnt1 three cycles later, done pulses in that order.
REQ-042 Write strobes: req1 writes 16'h00A5 to C016 -> lfsr_load high for exactly 1 cycle with bus_oe = 1, bus_wdata = 16'h00A5 and mm_re = 0; a write to C00B produces br_stats_wr likewise.
REQ-043 Out of range: req0 reads 16'h8000 -> no mm_re, done0 one cycle after gnt0 with err = 1 and rdata = 16'h0000.
REQ-044 Reset abort: rst asserted during ACCESS of a write to C00B -> br_stats_wr drops in the same cycle, no done0, state returns to IDLE.
REQ-045 Sustained contention: both requesters held for 10 transactions -> grants strictly alternate 0,1,0,1 and no done overlaps.
